// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, register count and writeback request type
package regfile_pkg;
    localparam int NREQ   = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction
endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: three-way round-robin arbiter, search starts at ptr and wraps
module rr_arbiter3
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    output logic [NREQ-1:0] grant
);
    logic [1:0] ptr_q, ptr_d, idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    // Walk downward so the lowest offset from ptr wins the last assignment
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        idx   = '0;
        if (enable && rst_n) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx = wrap3(3'(ptr_q) + 3'(k));
                if (req[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    ptr_d      = wrap3(3'(idx) + 3'd1);
                end
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates three writeback sources into a single
// registered output stage that drives the register-file write port.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0] req_data,
    output logic [NREQ-1:0]             req_ready,
    input  logic                        wb_stall,
    input  logic                        flush,
    output logic [ADDR_W-1:0]           RD,
    output logic [DATA_W-1:0]           WD,
    output logic                        wr_enable,
    output logic [NREGS-1:0]            busy
);
    logic    out_valid_q, out_valid_d, can_accept, load;
    wb_req_t out_q, out_d, sel;

    assign can_accept = (~out_valid_q | ~wb_stall) & ~flush;

    rr_arbiter3 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .enable (can_accept),
        .grant  (req_ready)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) sel = '{addr: req_addr[i], data: req_data[i]};
    end

    // Writes to register 0 are consumed but never staged
    assign load      = |req_ready && sel.addr != '0;
    assign wr_enable = out_valid_q & ~wb_stall & ~flush;

    always_comb begin
        out_d       = load ? sel : out_q;
        out_valid_d = flush ? 1'b0 : load ? 1'b1 : wr_enable ? 1'b0 : out_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign RD   = out_q.addr;
    assign WD   = out_q.data;
    assign busy = out_valid_q ? ({{(NREGS-1){1'b0}}, 1'b1} << out_q.addr) : '0;
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters: NREQ = 3 (fixed number of writeback requesters); DATA_W = 32 (write-data width); ADDR_W = 4 (register-address width, 16 registers).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 req_valid  input  NREQ  per-requester write request valid (0 = ALU writeback, 1 = load return, 2 = debug port).
REQ-005 req_addr  input  NREQ x ADDR_W  destination register per requester.
REQ-006 req_data  input  NREQ x DATA_W  write data per requester.
REQ-007 req_ready  output  NREQ  one-hot or zero; high only for the requester accepted this cycle.
REQ-008 wb_stall  input  1  hold: the pending write is not issued this cycle.
REQ-009 flush  input  1  synchronous discard of the pending write.
REQ-010 RD  output  ADDR_W  register-file write address.
REQ-011 WD  output  DATA_W  register-file write data.
REQ-012 wr_enable  output  1  register-file write strobe.
REQ-013 busy  output  16  busy[r] = 1 while a write to register r is pending in the output stage.

Function
REQ-014 The output stage is a single entry: out_valid, out_addr, out_data, all held in flops.
REQ-015 can_accept = ~out_valid | ~wb_stall, and ~flush.
REQ-016 Request i is accepted in a cycle when req_valid[i] = 1, can_accept = 1, and i is the first valid requester found by searching upward from ptr modulo 3.
REQ-017 Only one request is accepted per cycle; req_ready[i] is asserted, combinationally, only for the accepted requester.
REQ-018 ptr resets to 0; after requester i is accepted, ptr = (i+1) mod 3; ptr is unchanged in any cycle with no acceptance.
REQ-019 An accepted request is loaded into the output stage at the next edge: out_valid = 1 and addr/data are captured. Latency is exactly 1 cycle from acceptance to wr_enable, when wb_stall = 0.
REQ-020 An accepted request with req_addr = 0 is consumed (ready = 1) but never loaded. Register 0 is never written, and busy[0] is always 0.
REQ-021 wr_enable = out_valid & ~wb_stall & ~flush. RD = out_addr, and WD = out_data.
REQ-022 When wr_enable = 1 and no new request is accepted, out_valid clears at the edge. Issue and accept in the same cycle replace the entry back-to-back, giving one write per cycle.
REQ-023 While wb_stall = 1 and out_valid = 1, the entry, RD/WD and busy hold. No requester is ready, and every request waits with valid held.
REQ-024 flush = 1: wr_enable = 0, req_ready = 0, out_valid clears at the edge, and ptr holds. Flush dominates stall and accept.
REQ-025 busy = one-hot decode of out_addr when out_valid = 1, else all 0. busy is registered-derived, so it is glitch-free relative to inputs.
REQ-026 A requester that deasserts req_valid without having seen ready is simply not granted. No state is retained for that requester.

Reset
REQ-027 While rst_n = 0: out_valid = 0, out_addr = 0, out_data = 0, ptr = 0; hence wr_enable = 0, RD = 0, WD = 0, busy = 0, req_ready = 0.
REQ-028 Reset asserted mid-operation discards any pending write without issuing it. Operation resumes on the first edge after rst_n rises.

Structure
REQ-029 Shared package regfile_pkg holds DATA_W, ADDR_W, NREQ, NREGS = 16, and a packed struct wb_req_t {addr, data}.
REQ-030 One sub-module, rr_arbiter3, implements the ptr register and first-valid search. Its inputs are req, enable, rst_n and clk; its output is the one-hot grant.
REQ-031 The block connects to the register file's RD/WD/wr_enable ports with no further logic between them.

Verification
REQ-032 Reset, then req_valid = 001, addr 5, data 0xDEADBEEF -> req_ready = 001 in cycle 0; in cycle 1, wr_enable = 1, RD = 5, WD = 0xDEADBEEF, busy = 0x0020.
REQ-033 All three requesters held valid (addrs 1/2/3) for 6 cycles -> grants 0,1,2,0,1,2; wr_enable high for 6 consecutive cycles starting 1 cycle after the first grant.
REQ-034 Pending write to reg 7 with wb_stall = 1 for 3 cycles -> RD = 7 is held, busy[7] = 1, req_ready = 0, wr_enable = 0; the write is issued on the first unstalled cycle.
REQ-035 Request to addr 0 with data 0x1234 -> ready = 1, then wr_enable stays 0 and busy stays 0; ptr still advances.
REQ-036 Pending write to reg 9 with flush = 1 and requester 1 valid in the same cycle -> no write issued, req_ready = 0, busy = 0 next cycle, and requester 1 is granted in the following cycle.
REQ-037 rst_n pulled low asynchronously mid-cycle with a pending write to reg 3 -> wr_enable, RD, WD and busy go to 0 immediately, and no write to reg 3 ever occurs.
